// File: rtl/nibbler_pkg.sv
// Shared definitions for the Nibbler sequencer slice: control-word bit
// indices, the commit mask and the sequencer state encoding.
package nibbler_pkg;

    localparam int CTRL_W = 13;

    // Control-word bit positions, MSB first.
    localparam int INC_PC      = 12;
    localparam int LOAD_PC     = 11;
    localparam int LOAD_A      = 10;
    localparam int LOAD_FLAGS  = 9;
    localparam int ALU_SEL_MSB = 8;
    localparam int ALU_SEL_LSB = 6;
    localparam int CS_RAM      = 5;
    localparam int WE_RAM      = 4;
    localparam int OE_ALU      = 3;
    localparam int OE_IN       = 2;
    localparam int OE_OPRND    = 1;
    localparam int LOAD_OUT    = 0;

    // Strobes that change architectural state; these are held off until
    // the final cycle of a phase. The rest are levels that may pass freely.
    localparam logic [CTRL_W-1:0] COMMIT_MASK = 13'b1111000010001;

    typedef enum logic [1:0] {
        ST_HALT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_EXEC     = 2'd2,
        ST_RAM_WAIT = 2'd3
    } seq_state_e;

    // Keep only the hold (non-committing) bits of a control word.
    function automatic logic [CTRL_W-1:0] hold_only(input logic [CTRL_W-1:0] word);
        return word & ~COMMIT_MASK;
    endfunction

endpackage

// File: rtl/nibbler_sequencer_if.sv
// Bus between the board/microcode side (master) and the sequencer (slave).
// Breakpoint signals exist only when NIBBLER_BREAKPOINT_EN is defined.
interface nibbler_sequencer_if;
    import nibbler_pkg::*;

    logic              run;
    logic              step;
    logic [CTRL_W-1:0] ctrl_in;
    logic              phase;
    logic [CTRL_W-1:0] ctrl_out;
    logic              fetch_en;
    logic              halted;
    logic              busy;
`ifdef NIBBLER_BREAKPOINT_EN
    logic [11:0]       pc;
    logic [11:0]       bkpt_addr;
    logic              bkpt_en;
    logic              bkpt_hit;
`endif

    modport master (
        output run, step, ctrl_in,
`ifdef NIBBLER_BREAKPOINT_EN
        output pc, bkpt_addr, bkpt_en,
        input  bkpt_hit,
`endif
        input  phase, ctrl_out, fetch_en, halted, busy
    );

    modport slave (
        input  run, step, ctrl_in,
`ifdef NIBBLER_BREAKPOINT_EN
        input  pc, bkpt_addr, bkpt_en,
        output bkpt_hit,
`endif
        output phase, ctrl_out, fetch_en, halted, busy
    );

endinterface

// File: rtl/nibbler_wait_counter.sv
// 4-bit loadable down-counter for RAM wait states. last_o flags the final
// wait cycle (count == 1), which is where the deferred commit happens.
module nibbler_wait_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       last_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Load has priority over decrement; the counter saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    // Counter register, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == 4'd1);

endmodule

// File: rtl/nibbler_sequencer.sv
// Fetch/execute sequencer for the Nibbler 4-bit core: drives the microcode
// phase bit, defers commit strobes to the last cycle of each phase, inserts
// RAM wait states and provides run/halt/single-step control.
// Optional breakpoint support is enabled with NIBBLER_BREAKPOINT_EN.
//
// state       | meaning
// ST_HALT     | idle at an instruction boundary, control word forced to 0
// ST_FETCH    | phase 0, fetch register loads, word passes through
// ST_EXEC     | phase 1, commits unless a RAM access needs wait states
// ST_RAM_WAIT | phase 1, commit bits held off until the last wait cycle
module nibbler_sequencer
    import nibbler_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int CTRL_W      = nibbler_pkg::CTRL_W
) (
    input  logic                clock,
    input  logic                reset,
    nibbler_sequencer_if.slave  bus
);

    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    seq_state_e        state_q, state_d;
    logic              step_q;
    logic              step_mode_q, step_mode_d;
    logic              step_edge;
    logic              enter_wait;
    logic              cnt_load, cnt_dec, cnt_last;
    logic              bkpt_stop;
    seq_state_e        done_state;
    logic [CTRL_W-1:0] ctrl_hold;

    assign step_edge  = bus.step & ~step_q;
    assign enter_wait = bus.ctrl_in[CS_RAM] & HAS_WAIT;
    assign ctrl_hold  = hold_only(bus.ctrl_in);

`ifdef NIBBLER_BREAKPOINT_EN
    logic [11:0] next_pc;
    logic        bkpt_hit_q, bkpt_hit_d;

    // The pc the next fetch would use, given this cycle's committed inc_pc.
    assign next_pc   = bus.ctrl_in[INC_PC] ? (bus.pc + 12'd1) : bus.pc;
    assign bkpt_stop = bus.bkpt_en && (next_pc == bus.bkpt_addr);
    assign bus.bkpt_hit = bkpt_hit_q;
`else
    assign bkpt_stop = 1'b0;
`endif

    // Where an instruction goes once its commit cycle is done.
    assign done_state = (bus.run && !step_mode_q && !bkpt_stop) ? ST_FETCH : ST_HALT;

    nibbler_wait_counter u_wait_counter (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (cnt_load),
        .load_val_i (WAIT_LOAD),
        .dec_i      (cnt_dec),
        .last_o     (cnt_last)
    );

    // State, step edge detector and step-mode registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_HALT;
            step_q      <= 1'b0;
            step_mode_q <= 1'b0;
`ifdef NIBBLER_BREAKPOINT_EN
            bkpt_hit_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= bus.step;
            step_mode_q <= step_mode_d;
`ifdef NIBBLER_BREAKPOINT_EN
            bkpt_hit_q  <= bkpt_hit_d;
`endif
        end
    end

    // Next-state decode.
    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        case (state_q)
            ST_HALT: begin
                if (bus.run || step_edge) begin
                    state_d     = ST_FETCH;
                    step_mode_d = ~bus.run;
                end
            end
            ST_FETCH: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = enter_wait ? ST_RAM_WAIT : done_state;
            end
            ST_RAM_WAIT: begin
                if (cnt_last) begin
                    state_d = done_state;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

`ifdef NIBBLER_BREAKPOINT_EN
    // Breakpoint flag: set when a completing instruction is diverted to HALT
    // by the breakpoint, cleared when HALT is left.
    always_comb begin
        bkpt_hit_d = bkpt_hit_q;
        if ((state_q == ST_HALT) && (state_d != ST_HALT)) begin
            bkpt_hit_d = 1'b0;
        end else if (bus.run && !step_mode_q && bkpt_stop &&
                     (((state_q == ST_EXEC) && !enter_wait) ||
                      ((state_q == ST_RAM_WAIT) && cnt_last))) begin
            bkpt_hit_d = 1'b1;
        end
    end
`endif

    // Output decode from state, wait count and the raw control word.
    always_comb begin
        bus.phase    = 1'b0;
        bus.ctrl_out = '0;
        bus.fetch_en = 1'b0;
        bus.halted   = 1'b0;
        bus.busy     = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        case (state_q)
            ST_HALT: begin
                bus.halted = 1'b1;
            end
            ST_FETCH: begin
                bus.ctrl_out = bus.ctrl_in;
                bus.fetch_en = 1'b1;
            end
            ST_EXEC: begin
                bus.phase = 1'b1;
                if (enter_wait) begin
                    bus.ctrl_out = ctrl_hold;
                    cnt_load     = 1'b1;
                end else begin
                    bus.ctrl_out = bus.ctrl_in;
                end
            end
            ST_RAM_WAIT: begin
                bus.phase    = 1'b1;
                bus.busy     = 1'b1;
                cnt_dec      = 1'b1;
                bus.ctrl_out = cnt_last ? bus.ctrl_in : ctrl_hold;
            end
            default: begin
                bus.halted = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Directed bench for nibbler_sequencer with WAIT_STATES = 2. Each cycle the
// expected outputs are queued alongside the driven inputs and popped for
// comparison once the outputs have settled.
module tb_nibbler_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    typedef struct {
        logic        phase;
        logic [12:0] ctrl;
        logic        fe;
        logic        halted;
        logic        busy;
    } exp_t;

    exp_t sb[$];

    nibbler_sequencer_if bus ();

    nibbler_sequencer #(
        .WAIT_STATES (2),
        .CTRL_W      (13)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc_n, obs, exp);
        end
    endtask

    // One clock: drive inputs, queue expectation, then compare settled outputs.
    task automatic cyc(input logic rst, input logic r, input logic s, input logic [12:0] ci,
                       input logic ep, input logic [12:0] ec, input logic efe,
                       input logic eh, input logic eb);
        exp_t e;
        exp_t g;
        @(negedge clock);
        cyc_n++;
        reset       = rst;
        bus.run     = r;
        bus.step    = s;
        bus.ctrl_in = ci;
        e.phase = ep; e.ctrl = ec; e.fe = efe; e.halted = eh; e.busy = eb;
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        chk("phase",    {12'd0, bus.phase},    {12'd0, g.phase});
        chk("ctrl_out", bus.ctrl_out,          g.ctrl);
        chk("fetch_en", {12'd0, bus.fetch_en}, {12'd0, g.fe});
        chk("halted",   {12'd0, bus.halted},   {12'd0, g.halted});
        chk("busy",     {12'd0, bus.busy},     {12'd0, g.busy});
    endtask

    initial begin
        bus.run     = 1'b0;
        bus.step    = 1'b0;
        bus.ctrl_in = 13'h1FFF;
`ifdef NIBBLER_BREAKPOINT_EN
        bus.pc        = 12'h000;
        bus.bkpt_addr = 12'hFFF;
        bus.bkpt_en   = 1'b0;
`endif

        // Reset held with run low: halted, everything else quiet.
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 13'h1FFF, 0, 13'h0000, 0, 1, 0);
        cyc(0, 0, 0, 13'h1FFF, 0, 13'h0000, 0, 1, 0);
        cyc(0, 0, 0, 13'h1FFF, 0, 13'h0000, 0, 1, 0);

        // Free-run with a non-RAM word: phase alternates, word passes each cycle.
        cyc(0, 1, 0, 13'h1008, 0, 13'h0000, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 13'h1008, 0, 13'h1008, 1, 0, 0);
            cyc(0, 1, 0, 13'h1008, 1, 13'h1008, 0, 0, 0);
        end

        // RAM instruction: two wait states, load_a only on the last cycle.
        cyc(0, 1, 0, 13'h1008, 0, 13'h1008, 1, 0, 0);
        cyc(0, 1, 0, 13'h0420, 1, 13'h0020, 0, 0, 0);
        cyc(0, 1, 0, 13'h0420, 1, 13'h0020, 0, 0, 1);
        cyc(0, 1, 0, 13'h0420, 1, 13'h0420, 0, 0, 1);

        // Run dropped during RAM_WAIT: completes once, then halts.
        cyc(0, 1, 0, 13'h1008, 0, 13'h1008, 1, 0, 0);
        cyc(0, 1, 0, 13'h0420, 1, 13'h0020, 0, 0, 0);
        cyc(0, 0, 0, 13'h0420, 1, 13'h0020, 0, 0, 1);
        cyc(0, 0, 0, 13'h0420, 1, 13'h0420, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 13'h1FFF, 0, 13'h0000, 0, 1, 0);

        // Step held high for 5 cycles: exactly one instruction.
        cyc(0, 0, 1, 13'h1008, 0, 13'h0000, 0, 1, 0);
        cyc(0, 0, 1, 13'h1008, 0, 13'h1008, 1, 0, 0);
        cyc(0, 0, 1, 13'h1008, 1, 13'h1008, 0, 0, 0);
        cyc(0, 0, 1, 13'h1008, 0, 13'h0000, 0, 1, 0);
        cyc(0, 0, 1, 13'h1008, 0, 13'h0000, 0, 1, 0);
        cyc(0, 0, 0, 13'h1FFF, 0, 13'h0000, 0, 1, 0);

        // Second step edge, RAM instruction; an edge inside RAM_WAIT is ignored.
        cyc(0, 0, 1, 13'h1008, 0, 13'h0000, 0, 1, 0);
        cyc(0, 0, 1, 13'h1008, 0, 13'h1008, 1, 0, 0);
        cyc(0, 0, 1, 13'h0420, 1, 13'h0020, 0, 0, 0);
        cyc(0, 0, 0, 13'h0420, 1, 13'h0020, 0, 0, 1);
        cyc(0, 0, 1, 13'h0420, 1, 13'h0420, 0, 0, 1);
        cyc(0, 0, 1, 13'h1FFF, 0, 13'h0000, 0, 1, 0);
        cyc(0, 0, 1, 13'h1FFF, 0, 13'h0000, 0, 1, 0);
        cyc(0, 0, 0, 13'h1FFF, 0, 13'h0000, 0, 1, 0);

        // Run and step together: run wins, sequencer keeps fetching.
        cyc(0, 1, 1, 13'h1008, 0, 13'h0000, 0, 1, 0);
        cyc(0, 1, 1, 13'h1008, 0, 13'h1008, 1, 0, 0);
        cyc(0, 1, 0, 13'h1008, 1, 13'h1008, 0, 0, 0);
        cyc(0, 1, 0, 13'h1008, 0, 13'h1008, 1, 0, 0);

        // Reset asserted in RAM_WAIT: next cycle shows reset values.
        cyc(0, 1, 0, 13'h0420, 1, 13'h0020, 0, 0, 0);
        cyc(1, 1, 0, 13'h0420, 1, 13'h0020, 0, 0, 1);
        cyc(1, 1, 0, 13'h0420, 0, 13'h0000, 0, 1, 0);
        cyc(0, 0, 0, 13'h0420, 0, 13'h0000, 0, 1, 0);

        // After reset a RAM instruction again gets its full wait sequence.
        cyc(0, 1, 0, 13'h1008, 0, 13'h0000, 0, 1, 0);
        cyc(0, 1, 0, 13'h1008, 0, 13'h1008, 1, 0, 0);
        cyc(0, 1, 0, 13'h0420, 1, 13'h0020, 0, 0, 0);
        cyc(0, 1, 0, 13'h0420, 1, 13'h0020, 0, 0, 1);
        cyc(0, 1, 0, 13'h0420, 1, 13'h0420, 0, 0, 1);
        cyc(0, 1, 0, 13'h1008, 0, 13'h1008, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
